// File: rtl/piso_pkg.sv
// -----------------------------------------------------------------------------
// piso_pkg
// Shared definitions for the parallel-in / serial-out serializer.
//   state_t   : FSM encoding (ST_IDLE = 1'b0, ST_SHIFT = 1'b1)
//   cnt_width : bit-counter width for a given word width
// -----------------------------------------------------------------------------
package piso_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
  // A word width below 2 is not supported; return 1 to keep types legal.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_shift_core.sv
// -----------------------------------------------------------------------------
// piso_shift_core
// Shift register feeding the serial line.
//   clk, rst   : clock, asynchronous active-high reset
//   load       : capture load_data (takes priority over shift)
//   shift      : advance one bit toward the output end
//   active     : a word bit is on the line; otherwise IDLE_LEVEL is driven
//   load_data  : word to capture
//   serial_out : current serial bit
// -----------------------------------------------------------------------------
module piso_shift_core #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic             active,
  input  logic [WIDTH-1:0] load_data,
  output logic             serial_out
);

  logic [WIDTH-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= load_data;
    end else if (shift) begin
      if (MSB_FIRST) sr <= {sr[WIDTH-2:0], 1'b0};
      else           sr <= {1'b0, sr[WIDTH-1:1]};
    end
  end

  // The output bit is taken straight from the register end, gated by
  // 'active' which comes from the async-reset state flop, so the line
  // returns to IDLE_LEVEL the moment reset rises.
  assign serial_out = active ? (MSB_FIRST ? sr[WIDTH-1] : sr[0]) : IDLE_LEVEL;

endmodule

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
// Parallel-in, serial-out transmitter with one holding register so that
// consecutive words stream with no idle cycle between them.
//   clk, rst     : clock, asynchronous active-high reset
//   data_in      : parallel word to transmit
//   data_valid   : data_in is valid
//   data_ready   : a word can be accepted this cycle
//   serial_out   : serial data, one bit per cycle
//   serial_valid : serial_out carries a word bit
//   word_done    : high during the cycle the last bit of a word is on the line
//   busy         : shift register or holding register occupied
//   state_dbg    : current FSM state
//
// Handshake: a word transfers on every rising edge where
// data_valid && data_ready. data_ready is a function of registered state
// only (never of data_valid); data_valid may be raised at any time and the
// word is sampled only on the accepting edge.
// -----------------------------------------------------------------------------
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             word_done,
  output logic             busy,
  output state_t           state_dbg
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

  state_t           state, state_next;
  logic [CW-1:0]    bit_cnt, bit_cnt_next;
  logic [WIDTH-1:0] hold_reg, hold_next;
  logic             hold_full, hold_full_next;
  logic             ready_en;
  logic             word_done_next;
  logic             xfer;
  logic             core_load, core_shift;
  logic [WIDTH-1:0] core_data;

  // ready_en keeps data_ready low while reset is asserted and lets it rise
  // on the first clock edge after release.
  assign data_ready = ready_en && !hold_full;
  assign xfer       = data_valid && data_ready;

  always_comb begin
    state_next     = state;
    bit_cnt_next   = bit_cnt;
    hold_next      = hold_reg;
    hold_full_next = hold_full;
    core_load      = 1'b0;
    core_shift     = 1'b0;
    core_data      = data_in;

    case (state)
      ST_IDLE: begin
        if (xfer) begin
          core_load    = 1'b1;
          bit_cnt_next = '0;
          state_next   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt != LAST_BIT) begin
          core_shift   = 1'b1;
          bit_cnt_next = bit_cnt + CW'(1);
          // Mid-word acceptance parks the word; hold is known empty here
          // because data_ready would otherwise be low.
          if (xfer) begin
            hold_next      = data_in;
            hold_full_next = 1'b1;
          end
        end else if (hold_full) begin
          // Word boundary: the parked word goes next. No transfer can
          // coincide because data_ready is low while hold is full.
          core_load      = 1'b1;
          core_data      = hold_reg;
          hold_full_next = 1'b0;
          bit_cnt_next   = '0;
        end else if (xfer) begin
          core_load    = 1'b1;
          bit_cnt_next = '0;
        end else begin
          state_next   = ST_IDLE;
          bit_cnt_next = '0;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Registered so the pulse lines up with the last bit on the line.
    word_done_next = (state_next == ST_SHIFT) && (bit_cnt_next == LAST_BIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      hold_reg  <= '0;
      hold_full <= 1'b0;
      ready_en  <= 1'b0;
      word_done <= 1'b0;
    end else begin
      state     <= state_next;
      bit_cnt   <= bit_cnt_next;
      hold_reg  <= hold_next;
      hold_full <= hold_full_next;
      ready_en  <= 1'b1;
      word_done <= word_done_next;
    end
  end

  assign serial_valid = (state == ST_SHIFT);
  assign busy         = (state == ST_SHIFT) || hold_full;
  assign state_dbg    = state;

  piso_shift_core #(
    .WIDTH      (WIDTH),
    .MSB_FIRST  (MSB_FIRST),
    .IDLE_LEVEL (IDLE_LEVEL)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .load       (core_load),
    .shift      (core_shift),
    .active     (serial_valid),
    .load_data  (core_data),
    .serial_out (serial_out)
  );

endmodule
